// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared mode type and overflow helper for the pipelined adder
package adder_pkg;

  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_SUB = 1'b1
  } mode_e;

  localparam int MAX_STAGES = 8;

  // Signed overflow: operands agree in sign but the result does not.
  function automatic logic ovf_f(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/adder_pipe_stage.sv
// rtl/adder_pipe_stage.sv - one chunk of the carry-pipelined adder with its carry and valid registers
module adder_pipe_stage #(
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  logic [CHUNK:0] total;

  assign total = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

  // Register this chunk's result and carry; bubbles move through like beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
    end else if (en) begin
      out_valid <= in_valid;
      sum       <= total[CHUNK-1:0];
      cout      <= total[CHUNK];
    end
  end

endmodule

// File: rtl/adder_pipe.sv
// rtl/adder_pipe.sv - stallable carry-pipelined adder/subtractor with valid/ready on both sides
module adder_pipe
  import adder_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  mode_e            mode,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in0,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out,
  output logic             overflow_out
);

  localparam int CHUNK = WIDTH / STAGES;

  if (STAGES < 1 || STAGES > MAX_STAGES) begin : g_bad_stages
    $error("adder_pipe: STAGES must be in 1..8");
  end
  if (WIDTH % STAGES != 0) begin : g_bad_width
    $error("adder_pipe: WIDTH must be a multiple of STAGES");
  end

  // Stage k still carries the operand bits from chunk k upward; offsets pack those
  // shrinking slices (and the growing result slices) into single flat vectors.
  function automatic int op_off(input int k);
    int o = 0;
    for (int j = 0; j < k; j++) o += WIDTH - j * CHUNK;
    return o;
  endfunction

  function automatic int res_off(input int k);
    int o = 0;
    for (int j = 0; j < k; j++) o += (j + 1) * CHUNK;
    return o;
  endfunction

  localparam int OP_BITS  = op_off(STAGES);
  localparam int RES_BITS = res_off(STAGES);
  localparam int L_LO     = op_off(STAGES - 1);

  logic                adv;
  logic [WIDTH-1:0]    b_eff;
  logic [OP_BITS-1:0]  a_chain;
  logic [OP_BITS-1:0]  b_chain;
  logic [RES_BITS-1:0] r_chain;
  logic [STAGES-1:0]   v_chain;
  logic [STAGES-1:0]   c_chain;
  logic                am_q;
  logic                bm_q;

  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;
  assign b_eff    = (mode == MODE_SUB) ? ~in0 : in0;

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int REM  = WIDTH - k * CHUNK;
    localparam int A_LO = op_off(k);
    localparam int R_LO = res_off(k);

    logic [CHUNK-1:0] s_q;
    logic             c_in;
    logic             v_in;

    if (k == 0) begin : g_head
      assign a_chain[A_LO +: REM]   = in1;
      assign b_chain[A_LO +: REM]   = b_eff;
      assign c_in                   = (mode == MODE_SUB);
      assign v_in                   = in_valid;
      assign r_chain[R_LO +: CHUNK] = s_q;
    end else begin : g_body
      localparam int P_LO  = op_off(k - 1);
      localparam int PR_LO = res_off(k - 1);

      logic [REM-1:0]       a_sk;
      logic [REM-1:0]       b_sk;
      logic [k*CHUNK-1:0]   lo_q;

      // Skew the untouched upper operand chunks and deskew the finished low result chunks.
      always_ff @(posedge clk) begin
        if (rst) begin
          a_sk <= '0;
          b_sk <= '0;
          lo_q <= '0;
        end else if (adv) begin
          a_sk <= a_chain[P_LO+CHUNK +: REM];
          b_sk <= b_chain[P_LO+CHUNK +: REM];
          lo_q <= r_chain[PR_LO +: k*CHUNK];
        end
      end

      assign a_chain[A_LO +: REM]         = a_sk;
      assign b_chain[A_LO +: REM]         = b_sk;
      assign c_in                         = c_chain[k-1];
      assign v_in                         = v_chain[k-1];
      assign r_chain[R_LO +: (k+1)*CHUNK] = {s_q, lo_q};
    end

    adder_pipe_stage #(.CHUNK(CHUNK)) u_stage (
      .clk       (clk),
      .rst       (rst),
      .en        (adv),
      .in_valid  (v_in),
      .a         (a_chain[A_LO +: CHUNK]),
      .b         (b_chain[A_LO +: CHUNK]),
      .cin       (c_in),
      .out_valid (v_chain[k]),
      .sum       (s_q),
      .cout      (c_chain[k])
    );
  end

  // Keep the operand sign bits (B after inversion) beside the result for the overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      am_q <= 1'b0;
      bm_q <= 1'b0;
    end else if (adv) begin
      am_q <= a_chain[L_LO+CHUNK-1];
      bm_q <= b_chain[L_LO+CHUNK-1];
    end
  end

  assign out_valid    = v_chain[STAGES-1];
  assign carry_out    = c_chain[STAGES-1];
  assign sum_out      = r_chain[res_off(STAGES-1) +: WIDTH];
  assign overflow_out = ovf_f(am_q, bm_q, sum_out[WIDTH-1]);

endmodule

// File: tb/tb_adder_pipe.sv
// tb/tb_adder_pipe.sv - scoreboard bench for adder_pipe (8/2 and 32/4 configurations)
module tb_adder_pipe;
  import adder_pkg::*;

  localparam int W  = 8;
  localparam int S  = 2;
  localparam int WW = 32;
  localparam int SW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, in_valid, in_ready, out_valid, out_ready, carry_out, overflow_out;
  mode_e mode;
  logic [W-1:0] in1, in0, sum_out;

  logic in_valid_w, in_ready_w, out_valid_w, out_ready_w, carry_out_w, overflow_out_w;
  mode_e mode_w;
  logic [WW-1:0] in1_w, in0_w, sum_out_w;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         o;
    int           t;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic ofire, iacc, oc, oo;
  logic [W-1:0] os;
  int ot;

  adder_pipe #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
    .in1(in1), .in0(in0), .out_valid(out_valid), .out_ready(out_ready),
    .sum_out(sum_out), .carry_out(carry_out), .overflow_out(overflow_out)
  );

  adder_pipe #(.WIDTH(WW), .STAGES(SW)) dut_w (
    .clk(clk), .rst(rst), .in_valid(in_valid_w), .in_ready(in_ready_w), .mode(mode_w),
    .in1(in1_w), .in0(in0_w), .out_valid(out_valid_w), .out_ready(out_ready_w),
    .sum_out(sum_out_w), .carry_out(carry_out_w), .overflow_out(overflow_out_w)
  );

  function automatic exp_t model(input mode_e m, input logic [W-1:0] a, input logic [W-1:0] b, input int t);
    exp_t r;
    int sa, sbv, sr;
    sa  = int'($signed(a));
    sbv = int'($signed(b));
    if (m == MODE_SUB) begin
      r.s = a - b;
      r.c = (a >= b);
      sr  = sa - sbv;
    end else begin
      {r.c, r.s} = {1'b0, a} + {1'b0, b};
      sr = sa + sbv;
    end
    r.o = (sr > (2**(W-1)) - 1) || (sr < -(2**(W-1)));
    r.t = t;
    return r;
  endfunction

  task automatic tick();
    @(negedge clk);
    ofire = out_valid && out_ready;
    os = sum_out;
    oc = carry_out;
    oo = overflow_out;
    ot = cyc;
    iacc = in_valid && in_ready && !rst;
    if (iacc) sb.push_back(model(mode, in1, in0, cyc));
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; mode = MODE_ADD; in1 = '0; in0 = '0;
    in_valid_w = 1'b0; out_ready_w = 1'b1; mode_w = MODE_ADD; in1_w = '0; in0_w = '0;
    repeat (3) tick();
    rst = 1'b0;
    sb.delete();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (sum_out !== 8'h00) begin errors++; $display("FAIL reset_sum got=%h exp=00", sum_out); end
    checks++; if (carry_out !== 1'b0) begin errors++; $display("FAIL reset_carry got=%b exp=0", carry_out); end
    checks++; if (overflow_out !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", overflow_out); end
  endtask

  task automatic test_add_carry();
    int got = 0;
    mode = MODE_ADD; in1 = 8'hFF; in0 = 8'h01; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 10 && got == 0; i++) begin
      tick();
      if (ofire) begin
        got = 1;
        checks++;
        if ({os, oc, oo} !== {8'h00, 1'b1, 1'b0}) begin
          errors++; $display("FAIL add_ff_01 got=%h/%b/%b exp=00/1/0", os, oc, oo);
        end
        if (sb.size() > 0) begin
          e = sb.pop_front();
          checks++;
          if (ot - e.t != S) begin errors++; $display("FAIL add_latency got=%0d exp=%0d", ot - e.t, S); end
        end
      end
    end
    checks++; if (got == 0) begin errors++; $display("FAIL add_timeout got=no_output exp=output"); end
  endtask

  task automatic test_sub();
    logic [W-1:0] ta [2];
    logic [W-1:0] tb0 [2];
    logic [W+1:0] tx [2];
    int ni = 0;
    int no = 0;
    ta[0] = 8'h80; tb0[0] = 8'h01; tx[0] = {8'h7F, 1'b1, 1'b1};
    ta[1] = 8'h00; tb0[1] = 8'h01; tx[1] = {8'hFF, 1'b0, 1'b0};
    mode = MODE_SUB; out_ready = 1'b1;
    for (int c = 0; c < 20 && no < 2; c++) begin
      in_valid = (ni < 2);
      if (ni < 2) begin in1 = ta[ni]; in0 = tb0[ni]; end
      tick();
      if (iacc) ni++;
      if (ofire) begin
        checks++;
        if ({os, oc, oo} !== tx[no]) begin
          errors++; $display("FAIL sub_%0d got=%h exp=%h", no, {os, oc, oo}, tx[no]);
        end
        if (sb.size() > 0) void'(sb.pop_front());
        no++;
      end
    end
    in_valid = 1'b0;
    checks++; if (no != 2) begin errors++; $display("FAIL sub_count got=%0d exp=2", no); end
  endtask

  task automatic test_back_to_back();
    int ni = 0;
    int no = 0;
    int first = 0;
    out_ready = 1'b1;
    in1 = W'($urandom); in0 = W'($urandom); mode = mode_e'($urandom_range(0, 1));
    for (int c = 0; c < 60 && no < 16; c++) begin
      in_valid = (ni < 16);
      tick();
      if (iacc) begin
        ni++;
        in1 = W'($urandom); in0 = W'($urandom); mode = mode_e'($urandom_range(0, 1));
      end
      if (ofire) begin
        if (no == 0) first = ot;
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL b2b_extra got=%h exp=none", os);
        end else begin
          e = sb.pop_front();
          if ({os, oc, oo} !== {e.s, e.c, e.o}) begin
            errors++; $display("FAIL b2b_%0d got=%h/%b/%b exp=%h/%b/%b", no, os, oc, oo, e.s, e.c, e.o);
          end
        end
        checks++;
        if (ot != first + no) begin errors++; $display("FAIL b2b_gap_%0d got=%0d exp=%0d", no, ot, first + no); end
        no++;
      end
    end
    in_valid = 1'b0;
    checks++; if (no != 16) begin errors++; $display("FAIL b2b_count got=%0d exp=16", no); end
  endtask

  task automatic test_stall();
    int nacc = 0;
    int no = 0;
    logic [W-1:0] held;
    out_ready = 1'b0; in_valid = 1'b1;
    in1 = W'($urandom); in0 = W'($urandom); mode = mode_e'($urandom_range(0, 1));
    for (int c = 0; c < 2 + 5; c++) begin
      tick();
      if (iacc) begin
        nacc++;
        in1 = W'($urandom); in0 = W'($urandom); mode = mode_e'($urandom_range(0, 1));
      end
      if (c == 1) held = sum_out;
      if (c >= 2) begin
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready_%0d got=%b exp=0", c, in_ready); end
        checks++;
        if (sum_out !== held) begin errors++; $display("FAIL stall_hold_%0d got=%h exp=%h", c, sum_out, held); end
      end
    end
    out_ready = 1'b1;
    for (int c = 0; c < 40 && no < 8; c++) begin
      in_valid = (nacc < 8);
      tick();
      if (iacc) begin
        nacc++;
        in1 = W'($urandom); in0 = W'($urandom); mode = mode_e'($urandom_range(0, 1));
      end
      if (ofire) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL stall_extra got=%h exp=none", os);
        end else begin
          e = sb.pop_front();
          if ({os, oc, oo} !== {e.s, e.c, e.o}) begin
            errors++; $display("FAIL stall_out_%0d got=%h/%b/%b exp=%h/%b/%b", no, os, oc, oo, e.s, e.c, e.o);
          end
        end
        no++;
      end
    end
    in_valid = 1'b0;
    checks++; if (no != 8) begin errors++; $display("FAIL stall_count got=%0d exp=8", no); end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL stall_leftover got=%0d exp=0", sb.size()); end
  endtask

  task automatic test_reset_mid();
    int stale = 0;
    out_ready = 1'b1; in_valid = 1'b1; mode = MODE_ADD;
    for (int c = 0; c < 2; c++) begin
      in1 = W'($urandom); in0 = W'($urandom);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got=%b exp=1", in_ready); end
    out_ready = 1'b1;
    repeat (5) begin
      tick();
      if (ofire) stale++;
    end
    checks++; if (stale != 0) begin errors++; $display("FAIL midrst_stale got=%0d exp=0", stale); end
  endtask

  task automatic test_wide();
    int lat = 0;
    int got = 0;
    mode_w = MODE_ADD; in1_w = 32'h7FFF_FFFF; in0_w = 32'h0000_0001; out_ready_w = 1'b1;
    checks++; if (in_ready_w !== 1'b1) begin errors++; $display("FAIL wide_in_ready got=%b exp=1", in_ready_w); end
    in_valid_w = 1'b1;
    @(posedge clk); #1;
    in_valid_w = 1'b0;
    lat = 1;
    for (int i = 0; i < 12 && got == 0; i++) begin
      @(negedge clk);
      if (out_valid_w) begin
        got = 1;
        checks++;
        if (lat != SW) begin errors++; $display("FAIL wide_latency got=%0d exp=%0d", lat, SW); end
        checks++;
        if ({sum_out_w, carry_out_w, overflow_out_w} !== {32'h8000_0000, 1'b0, 1'b1}) begin
          errors++; $display("FAIL wide_sum got=%h/%b/%b exp=80000000/0/1", sum_out_w, carry_out_w, overflow_out_w);
        end
      end
      @(posedge clk); #1;
      lat++;
    end
    checks++; if (got == 0) begin errors++; $display("FAIL wide_timeout got=no_output exp=output"); end
  endtask

  initial begin
    test_reset();
    test_add_carry();
    test_sub();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_wide();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
